// File: rtl/reg_bus_master_pkg.sv
// Shared types and default sizing for the register bus master and its helpers.
// Holds the transaction FSM state encoding and the default parameter values.
package reg_bus_master_pkg;

  localparam int DEF_NUM_OF_PORTS   = 4;
  localparam int DEF_W_WIDTH        = 8;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // A single register slot still needs a one-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_master_timeout_counter.sv
// Saturating ACCESS-cycle counter; expired is high in the last allowed wait cycle.
// Zero latency on expired (decoded from the count flop); clear has priority over enable.
module reg_timeout_counter
  import reg_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holds at LAST so a stuck enable can never wrap back to a fresh budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/reg_bus_master.sv
// Host-command to register-bus master: one outstanding access, registered bus and response.
// Five cycles handshake-to-response with an immediate decoder; rsp held until rsp_ready, cmd_ready low while busy or ack high.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter  int NUM_OF_PORTS   = DEF_NUM_OF_PORTS,
  parameter  int W_WIDTH        = DEF_W_WIDTH,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int AW             = addr_width(NUM_OF_PORTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr_rd_s,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [W_WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               sel_en,
  output logic               wr_rd_s,
  output logic [AW-1:0]      addr,
  output logic [W_WIDTH-1:0] wdata,
  input  logic               ack,
  input  logic [W_WIDTH-1:0] rd_data
);

  state_e             state_q, state_d;
  logic               sel_en_q, sel_en_d;
  logic               wr_rd_s_q, wr_rd_s_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [W_WIDTH-1:0] wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cnt_clear;
  logic               cnt_expired;

  // A stale ack from the previous access must fall before the bus is reused.
  assign cmd_ready = rst_n && (state_q == IDLE) && !ack;

  reg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (state_q == ACCESS),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    sel_en_d    = sel_en_q;
    wr_rd_s_d   = wr_rd_s_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_clear   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = ACCESS;
          sel_en_d  = 1'b1;
          wr_rd_s_d = cmd_wr_rd_s;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          cnt_clear = 1'b1;
        end
      end
      ACCESS: begin
        // An ack arriving on the expiry edge still wins over the timeout.
        if (ack || cnt_expired) begin
          state_d     = DRAIN;
          sel_en_d    = 1'b0;
          wr_rd_s_d   = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          rsp_err_d   = !ack;
          rsp_rdata_d = (ack && !wr_rd_s_q) ? rd_data : '0;
        end
      end
      DRAIN: begin
        if (!ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_en_q    <= 1'b0;
      wr_rd_s_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_en_q    <= sel_en_d;
      wr_rd_s_q   <= wr_rd_s_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign sel_en    = sel_en_q;
  assign wr_rd_s   = wr_rd_s_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  a_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({rsp_valid, cmd_ready, sel_en}));

  a_bus_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    !sel_en |-> (!wr_rd_s && (addr == '0) && (wdata == '0)));

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: vector table plus hand sequences, scoreboarded responses.
module tb_reg_bus_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr_rd_s;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       sel_en, wr_rd_s;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  reg_bus_master #(.NUM_OF_PORTS(4), .W_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd_s(cmd_wr_rd_s),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr), .wdata(wdata),
    .ack(ack), .rd_data(rd_data)
  );

  // Decoder model: registered ack after ack_lat consecutive select cycles.
  logic       ack_q, stale_ack, respond_en;
  logic [7:0] rd_q;
  logic [7:0] regs [4];
  int         sel_run, ack_lat;

  assign ack     = ack_q | stale_ack;
  assign rd_data = rd_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rd_q    <= 8'h00;
      sel_run <= 0;
    end else begin
      sel_run <= sel_en ? sel_run + 1 : 0;
      if (sel_en && respond_en && (sel_run + 1 >= ack_lat)) begin
        ack_q <= 1'b1;
        rd_q  <= wr_rd_s ? 8'h00 : regs[addr];
        if (wr_rd_s) regs[addr] <= wdata;
      end else begin
        ack_q <= 1'b0;
        rd_q  <= 8'h00;
      end
    end
  end

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic       resp;
    int         ack_lat;
    int         hold;
    logic       err;
    logic [7:0] rdata;
    int         sel;
    int         lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_chk, n_pass, n_rsp;
  int   excl_bad, idle_bus_bad, spurious;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Response monitor: samples between the driver's negedge updates and the next posedge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (!$onehot0({rsp_valid, cmd_ready, sel_en})) excl_bad++;
      if (!sel_en && (wr_rd_s || addr != 2'd0 || wdata != 8'h00)) idle_bus_bad++;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          spurious++;
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          n_rsp++;
        end
      end
    end
  end

  task automatic wait_ready(input string nm, output bit ok);
    int t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = cmd_ready;
    chk({nm, "_handshake"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc, sel, bus_bad, lat, hold_bad;
    bit ok;
    logic [7:0] snap_d;
    logic snap_e;
    respond_en  = v.resp;
    ack_lat     = v.ack_lat;
    rsp_ready   = (v.hold == 0);
    cmd_valid   = 1'b1;
    cmd_wr_rd_s = v.wr;
    cmd_addr    = v.a;
    cmd_wdata   = v.d;
    wait_ready(nm, ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    sb_q.push_back('{err: v.err, rdata: v.rdata});
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 8'h00;
    cyc = 1; sel = 0; bus_bad = 0; lat = 0;
    while (cyc < 60) begin
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
      if (sel_en) begin
        sel++;
        if (wr_rd_s !== v.wr || addr !== v.a || wdata !== v.d) bus_bad++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(v.lat));
    chk({nm, "_sel_cycles"}, 32'(sel), 32'(v.sel));
    chk({nm, "_bus_fields"}, 32'(bus_bad), 32'd0);
    if (lat == 0) begin
      void'(sb_q.pop_back());
      return;
    end
    if (v.hold > 0) begin
      snap_d = rsp_rdata;
      snap_e = rsp_err;
      hold_bad = 0;
      for (int i = 0; i < v.hold; i++) begin
        if (!rsp_valid || rsp_rdata !== snap_d || rsp_err !== snap_e || cmd_ready) hold_bad++;
        @(negedge clk);
      end
      chk({nm, "_hold_stable"}, 32'(hold_bad), 32'd0);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int bad, rises, hs2, base, t;
    bit drop, prev_sel, prev_ack;
    n_chk = 0; n_pass = 0; n_rsp = 0;
    excl_bad = 0; idle_bus_bad = 0; spurious = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr_rd_s = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; stale_ack = 1'b0; respond_en = 1'b0; ack_lat = 1;
    regs[0] = 8'h00; regs[1] = 8'h3C; regs[2] = 8'h00; regs[3] = 8'h77;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({sel_en, wr_rd_s, addr, wdata, rsp_valid, rsp_err, rsp_rdata, cmd_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    //          wr    a     d      resp  lat hold err   rdata  sel lat
    vecs[0] = '{1'b1, 2'd2, 8'hA5, 1'b1, 1,  0,   1'b0, 8'h00, 2,  5};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 1'b1, 1,  0,   1'b0, 8'h3C, 2,  5};
    vecs[2] = '{1'b0, 2'd2, 8'h00, 1'b1, 1,  10,  1'b0, 8'hA5, 2,  5};
    vecs[3] = '{1'b1, 2'd3, 8'h5A, 1'b0, 1,  0,   1'b1, 8'h00, 16, 18};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1,  3,   1'b1, 8'h00, 16, 18};
    vecs[5] = '{1'b0, 2'd3, 8'h00, 1'b1, 15, 0,   1'b0, 8'h77, 16, 19};
    vecs[6] = '{1'b0, 2'd1, 8'h00, 1'b1, 16, 0,   1'b1, 8'h00, 16, 19};
    vecs[7] = '{1'b1, 2'd1, 8'hC3, 1'b1, 1,  0,   1'b0, 8'h00, 2,  5};
    vecs[8] = '{1'b0, 2'd1, 8'h00, 1'b1, 1,  4,   1'b0, 8'hC3, 2,  5};
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stale ack in IDLE must block acceptance until it falls.
    respond_en = 1'b1; ack_lat = 1; rsp_ready = 1'b1;
    stale_ack = 1'b1; cmd_valid = 1'b1; cmd_wr_rd_s = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h42;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (cmd_ready || sel_en) bad++;
      @(negedge clk);
    end
    chk("stale_ack_blocks", 32'(bad), 32'd0);
    stale_ack = 1'b0;
    #1;
    chk("stale_ack_release", 32'(cmd_ready), 32'd1);
    sb_q.push_back('{err: 1'b0, rdata: 8'h00});
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("stale_cmd_done", 32'(sb_q.size()), 32'd0);
    @(negedge clk);

    // Back-to-back with cmd_valid held high.
    base = n_rsp;
    cmd_valid = 1'b1; cmd_wr_rd_s = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h11;
    wait_ready("b2b_first", ok);
    sb_q.push_back('{err: 1'b0, rdata: 8'h00});
    sb_q.push_back('{err: 1'b0, rdata: 8'h11});
    @(negedge clk);
    cmd_wr_rd_s = 1'b0; cmd_wdata = 8'h00;
    rises = 0; hs2 = 0; bad = 0; drop = 1'b0; prev_sel = 1'b0; prev_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (drop) cmd_valid = 1'b0;
      if (sel_en && !prev_sel) begin
        rises++;
        if (prev_ack) bad++;
      end
      if (cmd_ready && cmd_valid) begin
        hs2++;
        drop = 1'b1;
      end
      prev_sel = sel_en;
      prev_ack = ack;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_sel_rises", 32'(rises), 32'd2);
    chk("b2b_second_handshake", 32'(hs2), 32'd1);
    chk("b2b_sel_after_ack_low", 32'(bad), 32'd0);
    chk("b2b_responses", 32'(n_rsp - base), 32'd2);
    chk("b2b_queue_empty", 32'(sb_q.size()), 32'd0);
    rsp_ready = 1'b0;

    // Reset during ACCESS aborts without a response.
    cmd_valid = 1'b1; cmd_wr_rd_s = 1'b1; cmd_addr = 2'd0; cmd_wdata = 8'h99;
    wait_ready("rst_mid", ok);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_mid_in_access", 32'(sel_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({sel_en, wr_rd_s, addr, wdata, rsp_valid, rsp_err, rsp_rdata, cmd_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_rsp; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || sel_en) bad++;
    end
    chk("rst_mid_no_activity", 32'(bad), 32'd0);
    chk("rst_mid_no_response", 32'(n_rsp - base), 32'd0);
    run_vec('{1'b0, 2'd1, 8'h00, 1'b1, 1, 0, 1'b0, 8'hC3, 2, 5}, "post_rst");

    repeat (3) @(negedge clk);
    chk("exclusive_outputs", 32'(excl_bad), 32'd0);
    chk("bus_quiet_outside_access", 32'(idle_bus_bad), 32'd0);
    chk("spurious_responses", 32'(spurious), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
REG_BUS_MASTER -- requirements
Module: reg_bus_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 Parameter NUM_OF_PORTS, 4, number of addressable register slots.
REQ-003 Parameter W_WIDTH, 8, register data width.
REQ-004 Parameter TIMEOUT_CYCLES, 16, maximum ACCESS cycles spent waiting for ack.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  asynchronous reset, active low.
REQ-007 cmd_valid  input  1  host command present.
REQ-008 cmd_ready  output  1  block can accept a command.
REQ-009 cmd_wr_rd_s  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  $clog2(NUM_OF_PORTS)  target register address.
REQ-011 cmd_wdata  input  W_WIDTH  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  host accepts the response.
REQ-014 rsp_rdata  output  W_WIDTH  read data, 0 for writes and errors.
REQ-015 rsp_err  output  1  1 = timeout, no ack received.
REQ-016 sel_en  output  1  bus select toward the register decoders.
REQ-017 wr_rd_s  output  1  bus direction, 1 = write.
REQ-018 addr  output  $clog2(NUM_OF_PORTS)  bus address.
REQ-019 wdata  output  W_WIDTH  bus write data.
REQ-020 ack  input  1  registered acknowledge from the decoders, OR-combined.
REQ-021 rd_data  input  W_WIDTH  registered read data from the decoders, OR-combined.

Function
REQ-022 The FSM SHALL use four states: IDLE, ACCESS, DRAIN, RESP.
REQ-023 In IDLE, cmd_ready SHALL equal !ack, so a new command is never accepted while a stale ack is high.
REQ-024 A handshake (cmd_valid & cmd_ready) in IDLE SHALL register wr_rd_s, addr and wdata and move to ACCESS.
REQ-025 In ACCESS, sel_en SHALL be 1 and wr_rd_s, addr and wdata SHALL hold stable.
REQ-026 ack sampled high in ACCESS SHALL capture rd_data into rsp_rdata for reads (0 for writes), clear rsp_err and move to DRAIN.
REQ-027 In ACCESS, a timeout counter SHALL increment each cycle; after TIMEOUT_CYCLES cycles without ack, the block SHALL move to DRAIN with rsp_err=1 and rsp_rdata=0.
REQ-028 In DRAIN, sel_en SHALL be 0; the block SHALL move to RESP on the first cycle ack is sampled low.
REQ-029 In RESP, rsp_valid SHALL be 1 with rsp_rdata and rsp_err stable; rsp_ready high SHALL move the block to IDLE.
REQ-030 Latency with an immediately acking decoder SHALL be 5 cycles: handshake in cycle 0, sel_en high in cycles 1-2, rsp_valid high from cycle 5.
REQ-031 rsp_valid, cmd_ready and sel_en SHALL never be high in the same cycle.
REQ-032 Bus outputs SHALL be driven from flops only; wr_rd_s, addr and wdata SHALL be 0 outside ACCESS.
REQ-033 The timeout counter SHALL clear on entry to ACCESS and SHALL saturate, never wrapping.
REQ-034 ack sampled high on the same edge the timeout expires SHALL be treated as success.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE and all outputs and registers to 0; cmd_ready SHALL follow !ack after release.
REQ-036 Reset asserted mid-transaction SHALL abort it with no response generated.

Structure
REQ-037 A shared package SHALL hold the state enum and the default values of NUM_OF_PORTS and W_WIDTH.
REQ-038 The timeout counter SHALL be one sub-module, reg_timeout_counter (clear, enable, expired).

Verification
REQ-039 Write addr=2, wdata=0xA5 to a responding decoder -> sel_en high 2 cycles with wr_rd_s=1, addr=2, wdata=0xA5; rsp_valid in cycle 5, rsp_err=0, rsp_rdata=0.
REQ-040 Read addr=1 with the register holding 0x3C -> rsp_rdata=0x3C, rsp_err=0.
REQ-041 No decoder responds, TIMEOUT_CYCLES=16 -> sel_en high exactly 16 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-042 rsp_ready held low 10 cycles -> rsp_valid and data stable for 10 cycles, cmd_ready=0 throughout.
REQ-043 Back-to-back commands with cmd_valid held high -> second sel_en only after ack has returned low; no merged or spurious responses.
REQ-044 rst_n pulsed low during ACCESS -> all outputs 0 that cycle, no rsp_valid, next command completes normally.
